// File: rtl/execute_muldiv.sv
// execute_muldiv: multi-cycle RV64M multiply/divide unit sitting beside the ALU.
// Handles MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and their W forms, one bit
// per cycle, and holds the result until the memory-stage side accepts it.
// Optional build macro: EXEC_MULDIV_EARLY_OUT_EN -- divide by zero and
// multiply by zero skip the iteration and complete one cycle after accept.
module execute_muldiv #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            is_word,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} stateT;

  localparam int SHW = XLEN - 32;

  stateT             state, stateNext;
  logic              accept, lastStep, calcEn;
  logic [CNT_W-1:0]  counter;
  logic [2:0]        opReg;
  logic              wordReg, negA, negB;
  logic [2*XLEN-1:0] accReg, accStep, prodSigned;
  logic [XLEN-1:0]   shiftReg, shiftStep, opBReg, resultReg;
  logic [XLEN-1:0]   remMag, rawRes, finalRes;
  logic [XLEN:0]     divPartial;
  logic [XLEN+1:0]   divDiff;
  logic              isDivIn, aSignedIn, bSignedIn, aNegIn, bNegIn;
  logic [XLEN-1:0]   aExt, bExt, aMag, bMag, shiftInit;

  // Operand preparation: extend word operands, take magnitudes, left-align the
  // iterated operand so the first step always sees its most significant bit.
  // NOTE: every signal written here gets a value on every path, so no latches.
  always_comb begin
    isDivIn   = op[2];
    aSignedIn = isDivIn ? ~op[0] : (~is_word & ((op == 3'd1) | (op == 3'd2)));
    bSignedIn = isDivIn ? ~op[0] : (~is_word & (op == 3'd1));
    if (is_word) begin
      aExt = {{SHW{aSignedIn & srca[31]}}, srca[31:0]};
      bExt = {{SHW{bSignedIn & srcb[31]}}, srcb[31:0]};
    end else begin
      aExt = srca;
      bExt = srcb;
    end
    aNegIn    = aSignedIn & aExt[XLEN-1];
    bNegIn    = bSignedIn & bExt[XLEN-1];
    aMag      = aNegIn ? -aExt : aExt;
    bMag      = bNegIn ? -bExt : bExt;
    shiftInit = is_word ? (aMag << SHW) : aMag;
  end

`ifdef EXEC_MULDIV_EARLY_OUT_EN
  logic            earlyHit;
  logic [XLEN-1:0] earlyResult;

  // Zero-operand shortcut: the answer is known from the operands alone.
  always_comb begin
    earlyHit = isDivIn ? (bExt == '0) : ((aExt == '0) | (bExt == '0));
    if (!isDivIn)   earlyResult = '0;
    else if (op[1]) earlyResult = is_word ? {{SHW{srca[31]}}, srca[31:0]} : srca;
    else            earlyResult = '1;
  end
`endif

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= stateNext;
  end

  // Next-state logic; flush wins over everything, including a new request.
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    lastStep  = 1'b0;
    if (flush) begin
      stateNext = IDLE;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          accept = 1'b1;
`ifdef EXEC_MULDIV_EARLY_OUT_EN
          stateNext = earlyHit ? DONE : CALC;
`else
          stateNext = CALC;
`endif
        end
        CALC: if (counter == CNT_W'(1)) begin
          lastStep  = 1'b1;
          stateNext = DONE;
        end
        DONE: if (out_ready) stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  assign calcEn    = (state == CALC) && !flush;
  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign result    = resultReg;

  // One iteration: MSB-first shift-add for multiply, restoring step for divide.
  always_comb begin
    divPartial = {accReg[XLEN-1:0], shiftReg[XLEN-1]};
    divDiff    = {1'b0, divPartial} - {2'b00, opBReg};
    if (opReg[2]) begin
      accStep   = {{(XLEN-1){1'b0}}, divDiff[XLEN+1] ? divPartial : divDiff[XLEN:0]};
      shiftStep = {shiftReg[XLEN-2:0], ~divDiff[XLEN+1]};
    end else begin
      accStep   = (accReg << 1) + (shiftReg[XLEN-1] ? {{XLEN{1'b0}}, opBReg} : '0);
      shiftStep = shiftReg << 1;
    end
  end

  // Result formation from the final iteration's values. Signed overflow needs
  // no special case: |min|/1 negated back is min, remainder 0. A signed
  // remainder by zero re-applies the dividend sign to |dividend|, giving the
  // dividend back; only the quotient needs the explicit all-ones override.
  always_comb begin
    prodSigned = (negA ^ negB) ? -accStep : accStep;
    remMag     = accStep[XLEN-1:0];
    if (opReg[2]) begin
      if (opReg[1])              rawRes = negA ? -remMag : remMag;
      else if (opBReg == '0)     rawRes = '1;
      else                       rawRes = (negA ^ negB) ? -shiftStep : shiftStep;
    end else if (wordReg || (opReg[1:0] == 2'd0)) begin
      rawRes = prodSigned[XLEN-1:0];
    end else begin
      rawRes = prodSigned[2*XLEN-1:XLEN];
    end
    finalRes = wordReg ? {{SHW{rawRes[31]}}, rawRes[31:0]} : rawRes;
  end

  // Datapath: latch the request on accept, iterate in CALC, register the result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      counter   <= '0;
      opReg     <= '0;
      wordReg   <= 1'b0;
      negA      <= 1'b0;
      negB      <= 1'b0;
      accReg    <= '0;
      shiftReg  <= '0;
      opBReg    <= '0;
      resultReg <= '0;
    end else if (accept) begin
      counter  <= is_word ? CNT_W'(32) : CNT_W'(XLEN);
      opReg    <= op;
      wordReg  <= is_word;
      negA     <= aNegIn;
      negB     <= bNegIn;
      accReg   <= '0;
      shiftReg <= shiftInit;
      opBReg   <= bMag;
`ifdef EXEC_MULDIV_EARLY_OUT_EN
      if (earlyHit) resultReg <= earlyResult;
`endif
    end else if (calcEn) begin
      counter  <= counter - CNT_W'(1);
      accReg   <= accStep;
      shiftReg <= shiftStep;
      if (lastStep) resultReg <= finalRes;
    end
  end

endmodule

// File: tb/tb_execute_muldiv.sv
// Directed bench for execute_muldiv (XLEN=64): arithmetic vectors, latency,
// backpressure, flush and asynchronous reset behaviour.
module tb_execute_muldiv;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic        is_word;
  logic [63:0] srca;
  logic [63:0] srcb;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        busy;

  int total = 0;
  int bad   = 0;

`ifdef EXEC_MULDIV_EARLY_OUT_EN
  localparam int ZLAT = 0;
`else
  localparam int ZLAT = 64;
`endif

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  execute_muldiv #(.XLEN(64), .CNT_W(7)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .is_word(is_word), .srca(srca), .srcb(srcb), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request, measure edges from accept to out_valid, check the
  // result, optionally stall the consumer, then drain.
  task automatic runOp(input string tag, input logic [2:0] o, input logic w,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input int expLat, input int hold);
    int lat;
    op = o; is_word = w; srca = a; srcb = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    srca = '0; srcb = '0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(expLat));
    check({tag, "_res"}, result, exp);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_holdres"}, result, exp);
      check({tag, "_holdvalid"}, {63'b0, out_valid}, 64'd1);
      check({tag, "_holdready"}, {63'b0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle"}, {62'b0, in_ready, out_valid}, 64'b10);
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; op = '0; is_word = 1'b0;
    srca = '0; srcb = '0; flush = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_in_ready", {63'b0, in_ready}, 64'd1);
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_result", result, 64'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Multiply family
    runOp("mul", 3'd0, 1'b0, 64'd3, -64'sd5, 64'hFFFF_FFFF_FFFF_FFF1, 64, 5);
    runOp("mulhu", 3'd3, 1'b0, ONES, 64'd2, 64'd1, 64, 0);
    runOp("mulh", 3'd1, 1'b0, ONES, 64'd2, ONES, 64, 0);
    runOp("mulhsu", 3'd2, 1'b0, 64'd2, ONES, 64'd1, 64, 0);
    runOp("mulw", 3'd0, 1'b1, 64'hDEAD_BEEF_7FFF_FFFF, 64'h1234_5678_0000_0002,
          64'hFFFF_FFFF_FFFF_FFFE, 32, 0);
    runOp("mul_zero", 3'd0, 1'b0, 64'd0, 64'd5, 64'd0, ZLAT, 0);

    // Divide family
    runOp("div", 3'd4, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64, 0);
    runOp("rem", 3'd6, 1'b0, -64'sd7, 64'd2, ONES, 64, 0);
    runOp("divu", 3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 64, 0);
    runOp("remu", 3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 64, 0);
    runOp("divw_ovf", 3'd4, 1'b1, 64'h0000_0000_8000_0000, ONES,
          64'hFFFF_FFFF_8000_0000, 32, 0);
    runOp("remw_ovf", 3'd6, 1'b1, 64'h0000_0000_8000_0000, ONES, 64'd0, 32, 0);
    runOp("div_ovf", 3'd4, 1'b0, 64'h8000_0000_0000_0000, ONES,
          64'h8000_0000_0000_0000, 64, 0);
    runOp("rem_ovf", 3'd6, 1'b0, 64'h8000_0000_0000_0000, ONES, 64'd0, 64, 0);
    runOp("divuw", 3'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 64'd16, 64'h0000_0000_0FFF_FFFF, 32, 0);
    runOp("divu_z", 3'd5, 1'b0, 64'd42, 64'd0, ONES, ZLAT, 0);
    runOp("rem_z", 3'd6, 1'b0, 64'd42, 64'd0, 64'd42, ZLAT, 0);

    // Flush at CALC cycle 10 with a competing request in the same cycle
    op = 3'd5; is_word = 1'b0; srca = 64'd1000; srcb = 64'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("flush_pre_busy", {63'b0, busy}, 64'd1);
    flush = 1'b1; in_valid = 1'b1; op = 3'd0; srca = 64'd9; srcb = 64'd9;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_idle", {61'b0, in_ready, busy, out_valid}, 64'b100);
    for (int i = 0; i < 3; i++) tick();
    check("flush_noaccept", {62'b0, busy, out_valid}, 64'b00);

    // Flush in IDLE blocks a simultaneous request
    in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle_req", {63'b0, busy}, 64'd0);

    // Asynchronous reset mid-CALC (result register holds 42 beforehand)
    op = 3'd0; is_word = 1'b0; srca = 64'd7; srcb = 64'd6; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("prereset_result", result, 64'd42);
    reset_n = 1'b0;
    #1;
    check("midrst_flags", {61'b0, in_ready, busy, out_valid}, 64'b100);
    check("midrst_result", result, 64'd0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("postrst_quiet", {62'b0, busy, out_valid}, 64'b00);

    // Unit recovers after reset
    runOp("recover", 3'd0, 1'b0, 64'd7, 64'd6, 64'd42, 64, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
